// File: rtl/pause_pkg.sv
// Shared types, default constants and the per-field 3-3-2 dimming helper for pause_dim_ctrl.
package pause_pkg;

  localparam logic [31:0] DIM_TIMEOUT_DEF     = 32'h0E4E1C00;
  localparam logic [15:0] DEBOUNCE_CYCLES_DEF = 16'd12000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    DIMMED = 2'd2
  } pause_state_t;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // Halve each colour field independently so no bit crosses into its neighbour.
  function automatic rgb332_t dim332(input rgb332_t px);
    rgb332_t o;
    o.r = px.r >> 1;
    o.g = px.g >> 1;
    o.b = px.b >> 1;
    return o;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter; outputs the accepted level and a one-cycle rise pulse.
module btn_debounce
  import pause_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        last_q, last_d;
  logic        stable_q, stable_d;
  logic        rise_q, rise_d;
  logic [15:0] cnt_q, cnt_d;

  // The counter restarts on every change of the synced level and parks at its terminal value.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    last_d   = sync2_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != last_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
      stable_d = last_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      last_q   <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      last_q   <= last_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = rise_q;

endmodule

// File: rtl/pause_dim_ctrl.sv
// Pause arbiter and frame-synchronous 3-3-2 video dimmer.
// Optional single-frame stepping while paused is enabled with `define PAUSE_FRAME_STEP_EN.
module pause_dim_ctrl
  import pause_pkg::*;
#(
  parameter logic [31:0] DIM_TIMEOUT     = DIM_TIMEOUT_DEF,
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       osd_open,
  input  logic       osd_pause_en,
  input  logic       hs_access,
`ifdef PAUSE_FRAME_STEP_EN
  input  logic       frame_step,
`endif
  input  logic       ce_pix,
  input  logic [7:0] rgb_in,
  input  logic       hblank_in,
  input  logic       vblank_in,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic       pause,
  output logic       user_paused,
  output logic       dim_active,
  output logic [7:0] rgb_out,
  output logic       hblank_out,
  output logic       vblank_out,
  output logic       hs_out,
  output logic       vs_out
);

  logic         btn_level, btn_rise, toggle;
  pause_state_t state_q, state_d;
  logic [31:0]  timer_q, timer_d;
  logic         pause_q, pause_d;
  logic         dim_q, dim_d;
  logic         vb_prev_q, vb_prev_d;
  logic [7:0]   rgb_q, rgb_d;
  logic         hb_q, hb_d, vb_q, vb_d, hs_q, hs_d, vs_q, vs_d;
  logic         vb_rise;
  logic         step_hold;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk    (clk_sys),
    .reset  (reset),
    .btn_raw(btn_pause),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  assign toggle  = btn_rise & btn_level;
  assign vb_rise = ce_pix & vblank_in & ~vb_prev_q;

`ifdef PAUSE_FRAME_STEP_EN
  logic fs_prev_q, fs_prev_d, armed_q, armed_d, stepping_q, stepping_d, fs_rise;

  assign fs_rise = frame_step & ~fs_prev_q;

  // A step is armed while paused, runs from one vblank rise to the next, and ignores re-arming meanwhile.
  always_comb begin
    fs_prev_d  = frame_step;
    armed_d    = armed_q;
    stepping_d = stepping_q;
    if (vb_rise) begin
      stepping_d = armed_q;
      armed_d    = 1'b0;
    end else if (fs_rise && user_paused && !stepping_q && !armed_q) begin
      armed_d = 1'b1;
    end
    if (!user_paused) armed_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      fs_prev_q  <= 1'b0;
      armed_q    <= 1'b0;
      stepping_q <= 1'b0;
    end else begin
      fs_prev_q  <= fs_prev_d;
      armed_q    <= armed_d;
      stepping_q <= stepping_d;
    end
  end

  assign step_hold = stepping_q;
`else
  assign step_hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      RUN: begin
        if (toggle) begin
          state_d = PAUSED;
          timer_d = '0;
        end
      end
      PAUSED: begin
        // Toggle beats a coincident timeout.
        if (toggle) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == DIM_TIMEOUT - 32'd1) begin
          state_d = DIMMED;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      DIMMED: begin
        if (toggle) begin
          state_d = RUN;
          timer_d = '0;
        end
      end
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
    if (step_hold && state_d != RUN) begin
      state_d = PAUSED;
      timer_d = '0;
    end
  end

  assign user_paused = (state_q != RUN);

  always_comb begin
    pause_d   = (user_paused & ~step_hold) | hs_access | (osd_open & osd_pause_en);
    vb_prev_d = ce_pix ? vblank_in : vb_prev_q;
    dim_d     = vb_rise ? (state_q == DIMMED) : dim_q;
    rgb_d     = rgb_q;
    hb_d      = hb_q;
    vb_d      = vb_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    // The new dim value already applies to the first pixel of the frame.
    if (ce_pix) begin
      rgb_d = dim_d ? dim332(rgb332_t'(rgb_in)) : rgb_in;
      hb_d  = hblank_in;
      vb_d  = vblank_in;
      hs_d  = hs_in;
      vs_d  = vs_in;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= RUN;
      timer_q   <= '0;
      pause_q   <= 1'b0;
      dim_q     <= 1'b0;
      vb_prev_q <= 1'b0;
      rgb_q     <= '0;
      hb_q      <= 1'b0;
      vb_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pause_q   <= pause_d;
      dim_q     <= dim_d;
      vb_prev_q <= vb_prev_d;
      rgb_q     <= rgb_d;
      hb_q      <= hb_d;
      vb_q      <= vb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign pause      = pause_q;
  assign dim_active = dim_q;
  assign rgb_out    = rgb_q;
  assign hblank_out = hb_q;
  assign vblank_out = vb_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed bench for pause_dim_ctrl with a pixel scoreboard and a small dim model.
`timescale 1ns/1ps
module tb_pause_dim_ctrl;
  import pause_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       btn_pause = 1'b0, osd_open = 1'b0, osd_pause_en = 1'b0, hs_access = 1'b0;
  logic       ce_pix = 1'b0;
  logic [7:0] rgb_in = '0;
  logic       hblank_in = 1'b0, vblank_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0;
  logic       pause, user_paused, dim_active, hblank_out, vblank_out, hs_out, vs_out;
  logic [7:0] rgb_out;
`ifdef PAUSE_FRAME_STEP_EN
  logic       frame_step = 1'b0;
`endif

  pause_dim_ctrl #(.DIM_TIMEOUT(32'd100), .DEBOUNCE_CYCLES(16'd16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .btn_pause   (btn_pause),
    .osd_open    (osd_open),
    .osd_pause_en(osd_pause_en),
    .hs_access   (hs_access),
`ifdef PAUSE_FRAME_STEP_EN
    .frame_step  (frame_step),
`endif
    .ce_pix      (ce_pix),
    .rgb_in      (rgb_in),
    .hblank_in   (hblank_in),
    .vblank_in   (vblank_in),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .pause       (pause),
    .user_paused (user_paused),
    .dim_active  (dim_active),
    .rgb_out     (rgb_out),
    .hblank_out  (hblank_out),
    .vblank_out  (vblank_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  int toggle_cnt = 0;
  int dimmed_cycles = 0;
  logic [31:0] toggle_timer = '0;
  logic m_req = 1'b0, m_dim = 1'b0, m_vb_prev = 1'b0;

  always @(posedge clk_sys) begin
    if (!reset && dut.toggle) begin
      toggle_cnt   <= toggle_cnt + 1;
      toggle_timer <= dut.timer_q;
    end
    if (dut.state_q == DIMMED) dimmed_cycles <= dimmed_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wait_paused(input string tag, input logic want, input int budget);
    int n = 0;
    while (user_paused !== want && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, user_paused, want);
  endtask

  task automatic press_toggle(input string tag, input logic want);
    btn_pause = 1'b1;
    wait_paused(tag, want, 80);
    btn_pause = 1'b0;
    tick(30);
  endtask

  // Drives one pixel, then checks the registered output and that it holds with ce_pix low.
  task automatic pix(input logic [7:0] rgb, input logic vb);
    logic [7:0]  e;
    logic [11:0] exp_v;
    rgb_in = rgb; vblank_in = vb; hblank_in = rgb[7] ^ vb; hs_in = rgb[0]; vs_in = vb & rgb[1];
    ce_pix = 1'b1;
    if (vb && !m_vb_prev) m_dim = m_req;
    m_vb_prev = vb;
    e = m_dim ? {1'b0, rgb[7:6], 1'b0, rgb[4:3], 1'b0, rgb[1]} : rgb;
    exp_q.push_back({rgb[7] ^ vb, vb, rgb[0], vb & rgb[1], e});
    tick(1);
    ce_pix = 1'b0;
    rgb_in = 8'($urandom_range(0, 255));
    exp_v = exp_q.pop_front();
    check("pix_out", {hblank_out, vblank_out, hs_out, vs_out, rgb_out}, exp_v);
    tick(1);
    check("pix_hold", {hblank_out, vblank_out, hs_out, vs_out, rgb_out}, exp_v);
  endtask

  initial begin
    int t0, nz, n;
    tick(3);
    check("rst_out", {pause, user_paused, dim_active}, 3'b000);
    check("rst_vid", {hblank_out, vblank_out, hs_out, vs_out, rgb_out}, 12'h000);
    reset = 1'b0;
    tick(5);

    // Long hold: one toggle, pause one cycle after user_paused, dim at cycle 100.
    t0 = toggle_cnt;
    btn_pause = 1'b1;
    wait_paused("hold_pause", 1'b1, 100);
    check("pause_lat0", pause, 1'b0);
    tick(1);
    check("pause_lat1", pause, 1'b1);
    tick(98);
    check("paused_99", 32'(dut.state_q), 32'(PAUSED));
    tick(1);
    check("dimmed_100", 32'(dut.state_q), 32'(DIMMED));
    check("dim_wait_vb", dim_active, 1'b0);
    tick(19880);
    check("hold_one_toggle", toggle_cnt - t0, 1);
    btn_pause = 1'b0;
    tick(40);
    check("release_no_toggle", toggle_cnt - t0, 1);

    // Dimming starts only at the vblank rise.
    m_req = 1'b1;
    pix(8'hFF, 1'b0);
    pix(8'hFF, 1'b0);
    check("dim_before_vb", dim_active, 1'b0);
    pix(8'hFF, 1'b1);
    check("dim_after_vb", dim_active, 1'b1);
    check("dim_ff", rgb_out, 8'b011_011_01);
    pix(8'hFF, 1'b1);
    pix(8'($urandom_range(0, 255)), 1'b0);
    pix(8'($urandom_range(0, 255)), 1'b0);

    press_toggle("unpause", 1'b0);
    m_req = 1'b0;
    pix(8'hFF, 1'b0);
    check("undim_wait_vb", dim_active, 1'b1);
    pix(8'hFF, 1'b1);
    check("undim_after_vb", dim_active, 1'b0);
    check("undim_ff", rgb_out, 8'hFF);
    pix(8'hA5, 1'b0);

    // Hiscore and OSD pause sources never touch the FSM.
    hs_access = 1'b1;
    tick(2);
    check("hs_pause", pause, 1'b1);
    nz = 0;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (pause !== 1'b1) nz++;
    end
    check("hs_pause_held", nz, 0);
    check("hs_user", user_paused, 1'b0);
    check("hs_state", 32'(dut.state_q), 32'(RUN));
    check("hs_timer", dut.timer_q, 32'd0);
    hs_access = 1'b0;
    tick(2);
    check("hs_off", pause, 1'b0);
    osd_open = 1'b1;
    tick(2);
    check("osd_no_en", pause, 1'b0);
    osd_pause_en = 1'b1;
    tick(2);
    check("osd_en", pause, 1'b1);
    osd_open = 1'b0;
    tick(2);
    check("osd_off", pause, 1'b0);
    osd_pause_en = 1'b0;

    // Chatter faster than the debounce window is rejected.
    t0 = toggle_cnt;
    for (int i = 0; i < 25; i++) begin
      btn_pause = ~btn_pause;
      tick(8);
    end
    check("chatter_none", toggle_cnt - t0, 0);
    btn_pause = 1'b1;
    wait_paused("chatter_settle", 1'b1, 60);
    check("chatter_one", toggle_cnt - t0, 1);
    btn_pause = 1'b0;
    tick(40);

    // Toggle lands in the same cycle as the timeout.
    n = 0;
    while (dut.timer_q != 32'd80 && n < 200) begin
      tick(1);
      n++;
    end
    check("timer_at_80", dut.timer_q, 32'd80);
    t0 = dimmed_cycles;
    btn_pause = 1'b1;
    tick(30);
    check("coinc_timer", toggle_timer, 32'd99);
    check("coinc_run", 32'(dut.state_q), 32'(RUN));
    check("coinc_never_dim", dimmed_cycles - t0, 0);
    check("coinc_dim_active", dim_active, 1'b0);
    btn_pause = 1'b0;
    tick(30);

    // Reset while dimmed drops everything on the next clock.
    press_toggle("pause_for_rst", 1'b1);
    tick(110);
    check("rst_pre_dimmed", 32'(dut.state_q), 32'(DIMMED));
    m_req = 1'b1;
    pix(8'h3C, 1'b0);
    pix(8'hFF, 1'b1);
    check("rst_pre_dim", dim_active, 1'b1);
    reset = 1'b1;
    tick(1);
    check("rst_mid_dim", dim_active, 1'b0);
    check("rst_mid_vid", {hblank_out, vblank_out, hs_out, vs_out, rgb_out}, 12'h000);
    check("rst_mid_user", user_paused, 1'b0);
    reset = 1'b0;
    m_req = 1'b0; m_dim = 1'b0; m_vb_prev = 1'b0;
    pix(8'h12, 1'b0);
    tick(20);

`ifdef PAUSE_FRAME_STEP_EN
    // One frame of run per step pulse; a pulse during the step frame is ignored.
    press_toggle("pause_for_step", 1'b1);
    frame_step = 1'b1;
    tick(1);
    frame_step = 1'b0;
    pix(8'h11, 1'b0);
    pix(8'h22, 1'b0);
    check("step_armed_paused", pause, 1'b1);
    pix(8'h33, 1'b1);
    check("step_low", pause, 1'b0);
    check("step_state", 32'(dut.state_q), 32'(PAUSED));
    hs_access = 1'b1;
    tick(2);
    check("step_hs_forces", pause, 1'b1);
    hs_access = 1'b0;
    tick(2);
    check("step_hs_release", pause, 1'b0);
    frame_step = 1'b1;
    tick(1);
    frame_step = 1'b0;
    pix(8'h44, 1'b1);
    pix(8'h55, 1'b0);
    pix(8'h66, 1'b0);
    check("step_still_low", pause, 1'b0);
    pix(8'h77, 1'b1);
    check("step_end_high", pause, 1'b1);
    pix(8'h01, 1'b0);
    pix(8'h02, 1'b1);
    check("second_step_ignored", pause, 1'b1);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
